// File: rtl/bist_pkg.sv
// -----------------------------------------------------------------------------
// bist_pkg
// Shared definitions for the BIST run controller:
//   - 3-bit state encodings (ST_*) for the run FSM
//   - clog2 helper used to size the phase counter
// No ports (package).
// -----------------------------------------------------------------------------
package bist_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_INIT  = 3'd1;
    localparam state_t ST_RUN   = 3'd2;
    localparam state_t ST_FLUSH = 3'd3;
    localparam state_t ST_CMP   = 3'd4;
    localparam state_t ST_DONE  = 3'd5;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bist_dcnt.sv
// -----------------------------------------------------------------------------
// bist_dcnt
// Loadable down-counter that saturates at zero (never wraps).
// Ports:
//   clk      in   rising-edge clock
//   reset    in   asynchronous, active-high; clears the count
//   load_i   in   load value_i (has priority over dec_i)
//   value_i  in   W-bit load value
//   dec_i    in   decrement by one while non-zero
//   zero_o   out  count is zero
// -----------------------------------------------------------------------------
module bist_dcnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] value_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = value_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/bist_sig_ctrl.sv
// -----------------------------------------------------------------------------
// bist_sig_ctrl
// BIST run controller and signature checker, sitting after the MISR.
// A run seeds the TPG/MISR pair for one cycle, enables both for PAT_CNT
// cycles, keeps only the MISR running for FLUSH_CYC cycles to drain the CUT
// pipeline, then captures the MISR signature and compares it to GOLDEN.
// The result is held until the next run or reset.
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high
//   start      in   request a run (honoured in IDLE and DONE only)
//   abort      in   cancel an active run, back to IDLE without a result
//   sig_in     in   SIG_W-bit MISR state
//   seed_o     out  one-cycle seed pulse to the TPG/MISR
//   tpg_en_o   out  TPG advance enable
//   misr_en_o  out  MISR enable
//   busy_o     out  run in progress
//   done_o     out  result valid
//   pass_o     out  captured signature matched GOLDEN (qualified by done_o)
//   sig_o      out  SIG_W-bit captured signature
// -----------------------------------------------------------------------------
module bist_sig_ctrl
    import bist_pkg::*;
#(
    parameter int               SIG_W     = 121,
    parameter int               PAT_CNT   = 1024,
    parameter int               FLUSH_CYC = 2,
    parameter logic [SIG_W-1:0] GOLDEN    = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [SIG_W-1:0] sig_in,
    output logic             seed_o,
    output logic             tpg_en_o,
    output logic             misr_en_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [SIG_W-1:0] sig_o
);

    // One counter serves both RUN and FLUSH, so it is sized for the longer.
    localparam int CNT_W = clog2((PAT_CNT > FLUSH_CYC) ? PAT_CNT + 1 : FLUSH_CYC + 1);
    localparam logic [CNT_W-1:0] RUN_LD   = CNT_W'(PAT_CNT - 1);
    localparam logic [CNT_W-1:0] FLUSH_LD = CNT_W'((FLUSH_CYC > 0) ? FLUSH_CYC - 1 : 0);

    state_t           state_q;
    state_t           state_d;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_value;
    logic             cnt_dec;
    logic             cnt_zero;
    logic [SIG_W-1:0] sig_q;
    logic [SIG_W-1:0] sig_d;
    logic             pass_q;
    logic             pass_d;

    bist_dcnt #(
        .W (CNT_W)
    ) u_dcnt (
        .clk     (clk),
        .reset   (reset),
        .load_i  (cnt_load),
        .value_i (cnt_value),
        .dec_i   (cnt_dec),
        .zero_o  (cnt_zero)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and counter control. abort outranks every other transition
    // in the busy states; it is ignored in IDLE and DONE.
    always_comb begin
        state_d   = state_q;
        cnt_load  = 1'b0;
        cnt_value = RUN_LD;
        cnt_dec   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_INIT;
                end
            end
            ST_INIT: begin
                cnt_load = 1'b1;
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                cnt_dec = 1'b1;
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (cnt_zero) begin
                    if (FLUSH_CYC > 0) begin
                        state_d   = ST_FLUSH;
                        cnt_load  = 1'b1;
                        cnt_value = FLUSH_LD;
                    end else begin
                        state_d = ST_CMP;
                    end
                end
            end
            ST_FLUSH: begin
                cnt_dec = 1'b1;
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (cnt_zero) begin
                    state_d = ST_CMP;
                end
            end
            ST_CMP: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_d = ST_INIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Signature capture: only a CMP cycle that is not aborted updates the
    // result, so an aborted run leaves the previous signature and verdict.
    always_comb begin
        sig_d  = sig_q;
        pass_d = pass_q;
        if ((state_q == ST_CMP) && !abort) begin
            sig_d  = sig_in;
            pass_d = (sig_in == GOLDEN);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sig_q  <= '0;
            pass_q <= 1'b0;
        end else begin
            sig_q  <= sig_d;
            pass_q <= pass_d;
        end
    end

    // Output decode: from state and capture registers only. The MISR must be
    // enabled during INIT as well, since it only takes the seed while enabled.
    always_comb begin
        seed_o    = 1'b0;
        tpg_en_o  = 1'b0;
        misr_en_o = 1'b0;
        busy_o    = 1'b0;
        done_o    = 1'b0;
        case (state_q)
            ST_INIT: begin
                seed_o    = 1'b1;
                misr_en_o = 1'b1;
                busy_o    = 1'b1;
            end
            ST_RUN: begin
                tpg_en_o  = 1'b1;
                misr_en_o = 1'b1;
                busy_o    = 1'b1;
            end
            ST_FLUSH: begin
                misr_en_o = 1'b1;
                busy_o    = 1'b1;
            end
            ST_CMP: begin
                busy_o = 1'b1;
            end
            ST_DONE: begin
                done_o = 1'b1;
            end
            default: begin
                busy_o = 1'b0;
            end
        endcase
        pass_o = pass_q && done_o;
        sig_o  = sig_q;
    end

endmodule
